// File: rtl/mem_access_ctrl.sv
// Load/store access controller between the MEM pipeline stage and a single-cycle-ack bus.
// Latches one access, aligns store data to byte lanes, flags misalignment and bus timeouts.
module mem_access_ctrl #(
    parameter logic [2:0] SZ_WORD   = 3'd0,
    parameter logic [2:0] SZ_HALF   = 3'd1,
    parameter logic [2:0] SZ_BYTE   = 3'd2,
    parameter logic [2:0] SZ_WLEFT  = 3'd3,
    parameter logic [2:0] SZ_WRIGHT = 3'd4,
    parameter logic [2:0] SZ_HALFU  = 3'd5,
    parameter logic [2:0] SZ_BYTEU  = 3'd6,
    parameter int         TIMEOUT   = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        op_valid,
    input  logic        op_write,
    input  logic [2:0]  op_size,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic        done,
    output logic [31:0] rdata,
    output logic [1:0]  bytesel,
    output logic        exc,
    output logic [1:0]  exc_code,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } state_t;

    state_t         state_r;
    state_t         state_next_s;
    logic [CW-1:0]  cnt_r;
    logic           accept_s;
    logic           misalign_s;
    logic           stall_s;
    logic [1:0]     code_next_s;

    logic           mem_req_r;
    logic           mem_we_r;
    logic [31:0]    mem_addr_r;
    logic [3:0]     mem_be_r;
    logic [31:0]    mem_wdata_r;
    logic [31:0]    rdata_r;
    logic [1:0]     bytesel_r;
    logic           done_r;
    logic           exc_r;
    logic [1:0]     exc_code_r;

    function automatic logic is_misaligned(input logic [2:0] size, input logic [1:0] a);
        logic mis;
        if (size == SZ_WORD) begin
            mis = (a != 2'b00);
        end else if ((size == SZ_HALF) || (size == SZ_HALFU)) begin
            mis = a[0];
        end else begin
            mis = 1'b0;
        end
        return mis;
    endfunction

    function automatic logic [3:0] lane_enables(input logic write, input logic [2:0] size,
                                                input logic [1:0] a);
        logic [3:0] be;
        if (!write) begin
            be = 4'b1111;
        end else if ((size == SZ_HALF) || (size == SZ_HALFU)) begin
            be = a[1] ? 4'b1100 : 4'b0011;
        end else if ((size == SZ_BYTE) || (size == SZ_BYTEU)) begin
            be = 4'b0001 << a;
        end else if (size == SZ_WLEFT) begin
            case (a)
                2'd0:    be = 4'b0001;
                2'd1:    be = 4'b0011;
                2'd2:    be = 4'b0111;
                default: be = 4'b1111;
            endcase
        end else if (size == SZ_WRIGHT) begin
            case (a)
                2'd0:    be = 4'b1111;
                2'd1:    be = 4'b1110;
                2'd2:    be = 4'b1100;
                default: be = 4'b1000;
            endcase
        end else begin
            be = 4'b1111;
        end
        return be;
    endfunction

    function automatic logic [31:0] lane_data(input logic [2:0] size, input logic [1:0] a,
                                              input logic [31:0] wd);
        logic [31:0] d;
        if ((size == SZ_HALF) || (size == SZ_HALFU)) begin
            d = wd << {a[1], 4'b0000};
        end else if ((size == SZ_BYTE) || (size == SZ_BYTEU) || (size == SZ_WRIGHT)) begin
            d = wd << {a, 3'b000};
        end else if (size == SZ_WLEFT) begin
            // swl places the most significant bytes of the register in the low lanes
            d = wd >> {~a, 3'b000};
        end else begin
            d = wd;
        end
        return d;
    endfunction

    assign accept_s   = (state_r == IDLE) && op_valid;
    assign misalign_s = is_misaligned(op_size, addr[1:0]);

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; an accepted access always runs to DONE or ERR
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (op_valid) begin
                    state_next_s = misalign_s ? ERR : REQ;
                end else begin
                    state_next_s = IDLE;
                end
            end
            REQ: begin
                if (mem_ack) begin
                    state_next_s = DONE;
                end else if (cnt_r == CNT_LAST) begin
                    state_next_s = ERR;
                end else begin
                    state_next_s = REQ;
                end
            end
            DONE:    state_next_s = IDLE;
            ERR:     state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // Output decode: combinational stall and the exception code for the coming ERR cycle
    always_comb begin
        stall_s     = op_valid && ((state_r == IDLE) || (state_r == REQ));
        code_next_s = 2'b00;
        if (state_next_s == ERR) begin
            if (state_r == IDLE) begin
                code_next_s = op_write ? 2'b10 : 2'b01;
            end else begin
                code_next_s = 2'b11;
            end
        end else begin
            code_next_s = 2'b00;
        end
    end

    // Registered status outputs follow the next state so they line up with it
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_req_r  <= 1'b0;
            done_r     <= 1'b0;
            exc_r      <= 1'b0;
            exc_code_r <= 2'b00;
        end else begin
            mem_req_r  <= (state_next_s == REQ);
            done_r     <= (state_next_s == DONE);
            exc_r      <= (state_next_s == ERR);
            exc_code_r <= code_next_s;
        end
    end

    // Bus-side fields are computed once at acceptance and held stable for the request
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_we_r    <= 1'b0;
            mem_addr_r  <= 32'h0000_0000;
            mem_be_r    <= 4'b0000;
            mem_wdata_r <= 32'h0000_0000;
            bytesel_r   <= 2'b00;
        end else if (accept_s) begin
            mem_we_r    <= op_write;
            mem_addr_r  <= {addr[31:2], 2'b00};
            mem_be_r    <= lane_enables(op_write, op_size, addr[1:0]);
            mem_wdata_r <= lane_data(op_size, addr[1:0], wdata);
            bytesel_r   <= addr[1:0];
        end else begin
            mem_we_r    <= mem_we_r;
            mem_addr_r  <= mem_addr_r;
            mem_be_r    <= mem_be_r;
            mem_wdata_r <= mem_wdata_r;
            bytesel_r   <= bytesel_r;
        end
    end

    // Read data capture; acks outside REQ never reach rdata
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata_r <= 32'h0000_0000;
        end else if ((state_r == REQ) && mem_ack) begin
            rdata_r <= mem_rdata;
        end else begin
            rdata_r <= rdata_r;
        end
    end

    // Timeout counter: cleared at acceptance, counts REQ cycles without ack
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_r <= CNT_ZERO;
        end else if (accept_s) begin
            cnt_r <= CNT_ZERO;
        end else if ((state_r == REQ) && !mem_ack) begin
            cnt_r <= cnt_r + CNT_ONE;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign stall     = stall_s;
    assign done      = done_r;
    assign rdata     = rdata_r;
    assign bytesel   = bytesel_r;
    assign exc       = exc_r;
    assign exc_code  = exc_code_r;
    assign mem_req   = mem_req_r;
    assign mem_we    = mem_we_r;
    assign mem_addr  = mem_addr_r;
    assign mem_be    = mem_be_r;
    assign mem_wdata = mem_wdata_r;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: each driven access pushes its expected bus
// fields and completion; a negedge monitor compares them when the DUT responds.
module tb_mem_access_ctrl;

    localparam logic [2:0] SZW  = 3'd0;
    localparam logic [2:0] SZH  = 3'd1;
    localparam logic [2:0] SZB  = 3'd2;
    localparam logic [2:0] SZWL = 3'd3;
    localparam logic [2:0] SZWR = 3'd4;
    localparam logic [2:0] SZHU = 3'd5;
    localparam logic [2:0] SZBU = 3'd6;
    localparam int         TO   = 16;

    logic        clk;
    logic        reset;
    logic        op_valid;
    logic        op_write;
    logic [2:0]  op_size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall;
    logic        done;
    logic [31:0] rdata;
    logic [1:0]  bytesel;
    logic        exc;
    logic [1:0]  exc_code;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    int n_checks;
    int n_pass;

    typedef struct {
        logic        is_exc;
        logic        no_req;
        logic [1:0]  code;
        logic [31:0] rdata;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  bsel;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;

    mem_access_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .op_valid  (op_valid),
        .op_write  (op_write),
        .op_size   (op_size),
        .addr      (addr),
        .wdata     (wdata),
        .stall     (stall),
        .done      (done),
        .rdata     (rdata),
        .bytesel   (bytesel),
        .exc       (exc),
        .exc_code  (exc_code),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_be    (mem_be),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    function automatic logic model_misalign(input logic [2:0] sz, input logic [1:0] a);
        if (sz == SZW) return (a != 2'b00);
        if ((sz == SZH) || (sz == SZHU)) return a[0];
        return 1'b0;
    endfunction

    // Lane-by-lane byte enables
    function automatic logic [3:0] model_be(input logic w, input logic [2:0] sz,
                                            input logic [1:0] a);
        logic [3:0] be;
        int ai;
        ai = int'(a);
        be = 4'b1111;
        if (w) begin
            for (int i = 0; i < 4; i++) begin
                case (sz)
                    SZH, SZHU: be[i] = ((i / 2) == int'(a[1]));
                    SZB, SZBU: be[i] = (i == ai);
                    SZWL:      be[i] = (i <= ai);
                    SZWR:      be[i] = (i >= ai);
                    default:   be[i] = 1'b1;
                endcase
            end
        end
        return be;
    endfunction

    // Lane i of the bus carries source byte src of wdata (zero when out of range)
    function automatic logic [31:0] model_wdata(input logic [2:0] sz, input logic [1:0] a,
                                                input logic [31:0] wd);
        logic [31:0] r;
        int src;
        r = 32'h0;
        for (int i = 0; i < 4; i++) begin
            case (sz)
                SZH, SZHU:       src = i - (a[1] ? 2 : 0);
                SZB, SZBU, SZWR: src = i - int'(a);
                SZWL:            src = i + 3 - int'(a);
                default:         src = i;
            endcase
            if ((src >= 0) && (src <= 3)) r[8*i +: 8] = wd[8*src +: 8];
        end
        return r;
    endfunction

    function automatic exp_t build_exp(input logic w, input logic [2:0] sz, input logic [31:0] a,
                                       input logic [31:0] wd, input int ack_at,
                                       input logic [31:0] rd);
        exp_t e;
        e.no_req = model_misalign(sz, a[1:0]);
        e.is_exc = e.no_req || (ack_at == 0);
        e.code   = e.no_req ? (w ? 2'b10 : 2'b01) : 2'b11;
        e.rdata  = rd;
        e.we     = w;
        e.be     = model_be(w, sz, a[1:0]);
        e.addr   = {a[31:2], 2'b00};
        e.wdata  = model_wdata(sz, a[1:0], wd);
        e.bsel   = a[1:0];
        return e;
    endfunction

    // Monitor: bus fields every request cycle, completion pops the scoreboard
    always @(negedge clk) begin
        if (reset) begin
            if (mem_req) begin
                if (sb_q.size() == 0) begin
                    chk("req_unexpected", 32'(mem_req), 32'd0);
                end else begin
                    mon_e = sb_q[0];
                    chk("req_on_misalign", 32'(mon_e.no_req), 32'd0);
                    chk("mem_we", 32'(mem_we), 32'(mon_e.we));
                    chk("mem_be", 32'(mem_be), 32'(mon_e.be));
                    chk("mem_addr", mem_addr, mon_e.addr);
                    if (mon_e.we) chk("mem_wdata", mem_wdata, mon_e.wdata);
                end
            end
            if (done || exc) begin
                if (sb_q.size() == 0) begin
                    chk("cpl_unexpected", 32'(done | exc), 32'd0);
                end else begin
                    mon_e = sb_q.pop_front();
                    chk("done", 32'(done), 32'(!mon_e.is_exc));
                    chk("exc", 32'(exc), 32'(mon_e.is_exc));
                    chk("exc_code", 32'(exc_code), mon_e.is_exc ? 32'(mon_e.code) : 32'd0);
                    chk("bytesel", 32'(bytesel), 32'(mon_e.bsel));
                    if (!mon_e.is_exc && !mon_e.we) chk("rdata", rdata, mon_e.rdata);
                end
            end
        end
    end

    // One access: ack on the ack_at-th request cycle (0 = never); drop releases op_valid early
    task automatic run_op(input logic w, input logic [2:0] sz, input logic [31:0] a,
                          input logic [31:0] wd, input int ack_at, input logic [31:0] rd,
                          input logic drop);
        exp_t e;
        int   exp_cyc;
        int   reqcnt;
        int   cyc;
        logic fin;
        e = build_exp(w, sz, a, wd, ack_at, rd);
        exp_cyc = e.no_req ? 1 : ((ack_at == 0) ? TO + 1 : ack_at + 1);
        sb_q.push_back(e);
        op_valid = 1'b1;
        op_write = w;
        op_size  = sz;
        addr     = a;
        wdata    = wd;
        reqcnt   = 0;
        cyc      = 0;
        fin      = 1'b0;
        while (!fin && (cyc < 40)) begin
            @(negedge clk);
            if (done || exc) begin
                fin = 1'b1;
                chk("latency", 32'(cyc), 32'(exp_cyc));
                if (!drop) chk("stall_end", 32'(stall), 32'd0);
                mem_ack  = 1'b0;
                op_valid = 1'b0;
            end else begin
                if (op_valid) chk("stall", 32'(stall), 32'd1);
                if (mem_req) begin
                    reqcnt++;
                    if (drop) op_valid = 1'b0;
                end
                mem_ack   = mem_req && (ack_at != 0) && (reqcnt == ack_at);
                mem_rdata = mem_ack ? rd : $urandom();
                cyc++;
            end
        end
        if (!fin) begin
            chk("op_timeout", 32'(cyc), 32'(exp_cyc));
            sb_q.delete();
            op_valid = 1'b0;
            mem_ack  = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got 0x%08h expected 0x%08h", 32'd1, 32'd0);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic       seen;
        logic [2:0] rsz;
        logic       rw;
        n_checks  = 0;
        n_pass    = 0;
        reset     = 1'b0;
        op_valid  = 1'b0;
        op_write  = 1'b0;
        op_size   = 3'd0;
        addr      = 32'h0;
        wdata     = 32'h0;
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        #12;
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_exc", 32'(exc), 32'd0);
        chk("rst_exc_code", 32'(exc_code), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_bytesel", 32'(bytesel), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        run_op(1'b0, SZW,  32'h0000_0100, 32'h0,          1, 32'hDEAD_BEEF, 1'b0);
        run_op(1'b1, SZB,  32'h0000_0203, 32'h0000_00AB,  1, 32'h0,         1'b0);
        run_op(1'b1, SZWL, 32'h0000_0301, 32'h1122_3344,  2, 32'h0,         1'b0);
        run_op(1'b0, SZH,  32'h0000_0101, 32'h0,          1, 32'h0,         1'b0);
        run_op(1'b1, SZW,  32'h0000_0102, 32'h5A5A_5A5A,  1, 32'h0,         1'b0);
        run_op(1'b1, SZW,  32'h0000_0400, 32'hFEED_FACE,  0, 32'h0,         1'b0);
        run_op(1'b1, SZH,  32'h0000_0202, 32'h0000_BEEF,  3, 32'h0,         1'b0);
        run_op(1'b1, SZWR, 32'h0000_0301, 32'h1122_3344,  1, 32'h0,         1'b0);
        run_op(1'b0, SZBU, 32'h0000_0003, 32'h0,          2, 32'h1234_5678, 1'b0);
        run_op(1'b0, SZW,  32'h0000_0104, 32'h0,          2, 32'hA5A5_0F0F, 1'b1);
        run_op(1'b0, SZHU, 32'h0000_00FF, 32'h0,          1, 32'h0,         1'b0);
        run_op(1'b0, SZWL, 32'h0000_0003, 32'h0,          1, 32'h0BAD_F00D, 1'b0);
        for (int k = 0; k < 10; k++) begin
            rsz = 3'($urandom_range(0, 6));
            rw  = ((rsz == SZHU) || (rsz == SZBU)) ? 1'b0 : 1'($urandom_range(0, 1));
            run_op(rw, rsz, $urandom(), $urandom(), $urandom_range(1, 4), $urandom(), 1'b0);
        end

        mem_ack = 1'b1;
        @(negedge clk);
        chk("idle_ack_done", 32'(done), 32'd0);
        chk("idle_ack_req", 32'(mem_req), 32'd0);
        mem_ack = 1'b0;
        @(posedge clk);
        #1;

        sb_q.push_back(build_exp(1'b1, SZW, 32'h0000_0500, 32'hCAFE_F00D, 0, 32'h0));
        op_valid = 1'b1;
        op_write = 1'b1;
        op_size  = SZW;
        addr     = 32'h0000_0503 & 32'hFFFF_FFFC;
        wdata    = 32'hCAFE_F00D;
        seen     = 1'b0;
        for (int k = 0; (k < 6) && !seen; k++) begin
            @(negedge clk);
            if (mem_req) seen = 1'b1;
        end
        chk("rst_req_seen", 32'(seen), 32'd1);
        op_valid = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        chk("async_mem_req", 32'(mem_req), 32'd0);
        chk("async_rdata", rdata, 32'd0);
        chk("async_bytesel", 32'(bytesel), 32'd0);
        sb_q.delete();
        #1;
        reset     = 1'b1;
        mem_ack   = 1'b1;
        mem_rdata = 32'h5555_AAAA;
        @(negedge clk);
        chk("stray_ack_done", 32'(done), 32'd0);
        chk("stray_ack_req", 32'(mem_req), 32'd0);
        mem_ack = 1'b0;
        @(negedge clk);
        chk("stray_ack_done2", 32'(done), 32'd0);
        chk("stray_rdata", rdata, 32'd0);
        @(posedge clk);
        #1;
        run_op(1'b0, SZW, 32'h0000_0600, 32'h0, 1, 32'h0123_4567, 1'b0);

        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
